// File: rtl/fft_pkg.sv
// fft_pkg: shared sizing constants and FSM encoding for the FFT twiddle sequencer.
// Constants: DATA_WIDTH (Q1.15 sample width), FFT_POINTS (N), ADDR_WIDTH (log2 N),
// STAGE_WIDTH (stage index width); state_t is the sequencer FSM encoding.
package fft_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int FFT_POINTS  = 64;
    localparam int ADDR_WIDTH  = 6;
    localparam int STAGE_WIDTH = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/fft_twiddle_skid.sv
// fft_twiddle_skid: 2-entry in-order output buffer between the ROM pipeline and the butterfly.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream side;
// out_valid/out_ready/out_data downstream side; count = current occupancy (0..2).
module fft_twiddle_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic             v0, v1;
    logic [WIDTH-1:0] d0, d1;
    logic             push, pop;

    // entry 0 is always the head; entry 1 is only valid when entry 0 is
    assign pop       = v0 & out_ready;
    assign in_ready  = ~v1 | pop;
    assign push      = in_valid & in_ready;
    assign out_valid = v0;
    assign out_data  = d0;
    assign count     = {1'b0, v0} + {1'b0, v1};

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else if (pop) begin
            if (v1)
                d0 <= d1;
            else if (push)
                d0 <= in_data;
            if (push)
                d1 <= in_data;
            v0 <= v1 | push;
            v1 <= v1 & push;
        end else if (push) begin
            if (v0) begin
                d1 <= in_data;
                v1 <= 1'b1;
            end else begin
                d0 <= in_data;
                v0 <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer: walks all radix-2 DIT stages/butterflies, reads twiddles from a
// 1-cycle-latency ROM and streams tagged twiddle beats over valid/ready.
// Ports: clk, rst (sync, active-high); start/busy/done sequence control;
// rom_addr/rom_real/rom_imag ROM interface; tw_valid/tw_ready handshake with
// tw_real/tw_imag/tw_stage/tw_bfly/tw_last beat payload.
module fft_twiddle_sequencer #(
    parameter int DATA_WIDTH  = fft_pkg::DATA_WIDTH,
    parameter int FFT_POINTS  = fft_pkg::FFT_POINTS,
    parameter int ADDR_WIDTH  = fft_pkg::ADDR_WIDTH,
    parameter int STAGE_WIDTH = fft_pkg::STAGE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_real,
    input  logic [DATA_WIDTH-1:0]  rom_imag,
    output logic                   tw_valid,
    input  logic                   tw_ready,
    output logic [DATA_WIDTH-1:0]  tw_real,
    output logic [DATA_WIDTH-1:0]  tw_imag,
    output logic [STAGE_WIDTH-1:0] tw_stage,
    output logic [ADDR_WIDTH-2:0]  tw_bfly,
    output logic                   tw_last
);
    import fft_pkg::*;

    localparam int BW = ADDR_WIDTH - 1;
    localparam int PW = 2 * DATA_WIDTH + STAGE_WIDTH + BW + 1;

    state_t                 state, state_n;
    logic [STAGE_WIDTH-1:0] s;
    logic [BW-1:0]          j, j_mask;
    logic [ADDR_WIDTH-1:0]  addr_k, addr_q;
    logic                   issue, is_last, credit_ok, skid_ready, pop;
    logic                   rd_valid, rd_last;
    logic [STAGE_WIDTH-1:0] rd_stage;
    logic [BW-1:0]          rd_bfly;
    logic [1:0]             occ;
    logic [PW-1:0]          beat;

    // k = (j mod 2^s) * N/2^(s+1): mask the low s bits of j, then shift up by (log2N-1-s)
    assign j_mask  = j & BW'((1 << s) - 1);
    assign addr_k  = {1'b0, j_mask} << (STAGE_WIDTH'(BW) - s);
    assign is_last = (s == STAGE_WIDTH'(ADDR_WIDTH - 1)) && (j == '1);
    assign pop     = tw_valid & tw_ready;
    // a new read may only start if everything already owed to the buffer, plus it, still fits
    assign credit_ok = (int'(occ) + int'(rd_valid) - int'(pop)) < 2;
    assign rom_addr  = issue ? addr_k : addr_q;
    assign busy      = state != IDLE;
    assign done      = pop & tw_last;

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN: begin
                issue   = credit_ok & skid_ready;
                state_n = (issue & is_last) ? DRAIN : RUN;
            end
            DRAIN:   state_n = (pop & tw_last) ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= '0;
            j        <= '0;
            addr_q   <= '0;
            rd_valid <= 1'b0;
            rd_stage <= '0;
            rd_bfly  <= '0;
            rd_last  <= 1'b0;
        end else begin
            addr_q   <= rom_addr;
            // tag stage lines up with the ROM output register
            rd_valid <= issue;
            if (issue) begin
                rd_stage <= s;
                rd_bfly  <= j;
                rd_last  <= is_last;
            end
            if (state == IDLE && start) begin
                s <= '0;
                j <= '0;
            end else if (issue && !is_last) begin
                j <= j + 1'b1;
                if (j == '1)
                    s <= s + 1'b1;
            end
        end
    end

    fft_twiddle_skid #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_ready  (skid_ready),
        .in_data   ({rd_last, rd_bfly, rd_stage, rom_imag, rom_real}),
        .out_valid (tw_valid),
        .out_ready (tw_ready),
        .out_data  (beat),
        .count     (occ)
    );

    assign {tw_last, tw_bfly, tw_stage, tw_imag, tw_real} = beat;
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// tb_fft_twiddle_sequencer: directed bench for fft_twiddle_sequencer with a behavioural
// 1-cycle registered twiddle ROM, per-beat order/payload checks and stall-hold checks.
module tb_fft_twiddle_sequencer;
    localparam int DW = 16;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst, start, tw_ready;
    logic          busy, done, tw_valid, tw_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_real, rom_imag, tw_real, tw_imag;
    logic [SW-1:0] tw_stage;
    logic [AW-2:0] tw_bfly;

    logic [DW-1:0] re_tab [N];
    logic [DW-1:0] im_tab [N];

    int checks = 0;
    int errors = 0;
    int idx    = 0;
    int ndone  = 0;
    int m_s, m_j, m_k;
    logic        stalled = 1'b0;
    logic [40:0] held    = '0;

    int lat, run, cyc, d0, nvalid;
    logic seen;

    always #5 clk = ~clk;

    fft_twiddle_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_real (rom_real),
        .rom_imag (rom_imag),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_real  (tw_real),
        .tw_imag  (tw_imag),
        .tw_stage (tw_stage),
        .tw_bfly  (tw_bfly),
        .tw_last  (tw_last)
    );

    always @(posedge clk) begin
        rom_real <= re_tab[rom_addr];
        rom_imag <= im_tab[rom_addr];
    end

    function automatic logic [15:0] q15(input real x);
        int v;
        v = (x >= 0.0) ? $rtoi(x * 32767.0 + 0.5) : -$rtoi(-x * 32767.0 + 0.5);
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            re_tab[k] = q15($cos(2.0 * 3.141592653589793 * k / N));
            im_tab[k] = q15(-$sin(2.0 * 3.141592653589793 * k / N));
        end
    end

    always @(negedge clk) begin
        if (stalled && tw_valid)
            check("hold", {tw_real, tw_imag, tw_stage, tw_bfly, tw_last}, held);
        if (tw_valid && tw_ready) begin
            m_s = idx / 32;
            m_j = idx % 32;
            m_k = (m_j % (1 << m_s)) * (N >> (m_s + 1));
            check("stage", tw_stage, m_s);
            check("bfly", tw_bfly, m_j);
            check("real", tw_real, re_tab[m_k]);
            check("imag", tw_imag, im_tab[m_k]);
            check("last", tw_last, idx == 191);
            check("done", done, idx == 191);
            if (m_s == 0) begin
                check("s0_real", tw_real, 16'h7FFF);
                check("s0_imag", tw_imag, 16'h0000);
            end
            if (m_s == 1 && m_j[0]) begin
                check("s1_odd_real", tw_real, 16'h0000);
                check("s1_odd_imag", tw_imag, 16'h8001);
            end
            if (m_s == 5 && m_j == 8) begin
                check("s5j8_real", tw_real, 16'h5A82);
                check("s5j8_imag", tw_imag, 16'hA57E);
            end
            idx++;
            ndone += int'(done);
        end else if (done) begin
            check("done_no_handshake", done, 1'b0);
        end
        stalled = tw_valid && !tw_ready;
        held    = {tw_real, tw_imag, tw_stage, tw_bfly, tw_last};
        if (start && !busy && !rst)
            idx = 0;
    end

    task automatic run_seq(output int lat_o, output int run_o);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat_o = 0;
        while (!tw_valid && lat_o < 20) begin
            @(posedge clk); #1;
            lat_o++;
        end
        run_o = 1;
        while (!done && run_o < 1000) begin
            @(posedge clk); #1;
            run_o++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tw_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", tw_valid, 1'b0);
        check("rst_last", tw_last, 1'b0);
        check("rst_addr", rom_addr, 6'd0);
        check("rst_real", tw_real, 16'd0);
        check("rst_imag", tw_imag, 16'd0);
        check("rst_stage", tw_stage, 3'd0);
        check("rst_bfly", tw_bfly, 5'd0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rst_over_start", busy, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", busy, 1'b0);

        tw_ready = 1'b1;
        d0 = ndone;
        run_seq(lat, run);
        check("a_latency", lat, 2);
        check("a_run_cycles", run, 192);
        check("a_busy_low", busy, 1'b0);
        check("a_beats", idx, 192);
        check("a_done_count", ndone - d0, 1);

        d0 = ndone;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 5000) begin
            tw_ready = 1'($urandom_range(0, 1));
            start    = (cyc == 40) || (tw_valid && tw_last && tw_ready);
            seen     = tw_valid && tw_last && tw_ready;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("b_finished", seen, 1'b1);
        check("b_busy_low", busy, 1'b0);
        nvalid = 0;
        repeat (4) begin
            @(posedge clk); #1;
            nvalid += int'(tw_valid) + int'(busy);
        end
        check("b_start_ignored", nvalid, 0);
        check("b_beats", idx, 192);
        check("b_done_count", ndone - d0, 1);

        tw_ready = 1'b1;
        d0 = ndone;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (idx < 100 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("c_reached_100", idx >= 100, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("c_valid_low", tw_valid, 1'b0);
        check("c_busy_low", busy, 1'b0);
        nvalid = 0;
        repeat (5) begin
            @(posedge clk); #1;
            nvalid += int'(tw_valid) + int'(done);
        end
        check("c_no_beats", nvalid, 0);
        check("c_no_done", ndone - d0, 0);
        run_seq(lat, run);
        check("c_restart_latency", lat, 2);
        check("c_restart_cycles", run, 192);
        check("c_restart_beats", idx, 192);
        check("c_restart_done", ndone - d0, 1);
        check("c_busy_low_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_twiddle_sequencer.md
FFT_TWIDDLE_SEQUENCER -- requirements
Module: fft_twiddle_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning twiddle sample width (Q1.15).
REQ-002 The block SHALL have parameter FFT_POINTS, default 64, meaning transform size N (power of two).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 6, meaning log2(FFT_POINTS).
REQ-004 The block SHALL have parameter STAGE_WIDTH, default 3, meaning width of the stage index (covers 0..ADDR_WIDTH-1).
REQ-005 The block SHALL have ports as follows:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one full twiddle sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when the last beat is accepted.
- rom_addr  out  ADDR_WIDTH  address to fft_twiddle_rom; 1-cycle registered read latency.
- rom_real  in  DATA_WIDTH  ROM real output.
- rom_imag  in  DATA_WIDTH  ROM imaginary output.
- tw_valid  out  1  output beat valid.
- tw_ready  in  1  downstream butterfly accepts the beat.
- tw_real  out  DATA_WIDTH  twiddle real part.
- tw_imag  out  DATA_WIDTH  twiddle imaginary part.
- tw_stage  out  STAGE_WIDTH  stage s of the beat.
- tw_bfly  out  ADDR_WIDTH-1  butterfly index j of the beat.
- tw_last  out  1  high on the final beat (s=ADDR_WIDTH-1, j=N/2-1).

Function
REQ-006 The block SHALL emit, per sequence, ADDR_WIDTH stages x N/2 butterflies = 192 beats at defaults, in order s ascending, then j ascending.
REQ-007 For each beat, rom_addr SHALL be k = (j mod 2^s) * (N / 2^(s+1)) (radix-2 DIT), always within 0..N/2-1.
REQ-008 The FSM SHALL have states IDLE, RUN and DRAIN; IDLE->RUN on start, RUN->DRAIN after the last address issues, DRAIN->IDLE when the last beat handshakes.
REQ-009 start SHALL be ignored while busy is high.
REQ-010 busy SHALL be high in RUN and DRAIN and low in IDLE.
REQ-011 A beat SHALL transfer only on a cycle with tw_valid and tw_ready both high.
REQ-012 While tw_valid is high and tw_ready is low, all tw_* outputs SHALL hold stable.
REQ-013 Returned ROM data SHALL be tagged with the s and j of the address that produced it; tags SHALL be carried through a delay pipeline matched to the ROM latency.
REQ-014 Beats SHALL land in a 2-entry output buffer.
REQ-015 A new address SHALL issue only when buffer occupancy plus in-flight reads is less than 2, so that no beat is ever dropped or overwritten.
REQ-016 With tw_ready held high, throughput SHALL be 1 beat per cycle.
REQ-017 The first tw_valid SHALL assert 2 cycles after the cycle in which start is sampled.
REQ-018 A simultaneous push and pop on a full or partially full buffer SHALL keep the occupancy unchanged and the order intact.
REQ-019 rom_addr SHALL hold its last value when no address is issuing.
REQ-020 The j counter SHALL wrap N/2-1 -> 0 while s increments; after s=ADDR_WIDTH-1, j=N/2-1, issue SHALL stop.
REQ-021 done SHALL pulse in the same cycle the tw_last beat handshakes, and busy SHALL drop on the next cycle.
REQ-022 start asserted in the same cycle as done SHALL be ignored; a new sequence requires start while in IDLE.

Reset
REQ-023 On rst, the FSM SHALL return to IDLE and the s and j counters SHALL clear.
REQ-024 On rst, the buffer SHALL empty and in-flight reads SHALL be discarded.
REQ-025 On rst, busy, done, tw_valid and tw_last SHALL be 0, and rom_addr, tw_real, tw_imag, tw_stage and tw_bfly SHALL be 0.
REQ-026 rst asserted mid-sequence SHALL abort the sequence with no further beats and no done pulse.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 DATA_WIDTH, FFT_POINTS, ADDR_WIDTH, STAGE_WIDTH and the FSM state encoding SHALL reside in the shared package fft_pkg.
REQ-029 The 2-entry buffer SHALL be a sub-module fft_twiddle_skid (valid/ready in, valid/ready out, payload = real, imag, stage, bfly, last).
REQ-030 Address generation and the FSM SHALL stay in the top module.

Verification
REQ-031 Scenario: start with tw_ready=1 and an fft_twiddle_rom instance -> 192 consecutive beats, first beat 2 cycles after start, then done and busy low.
REQ-032 Scenario: stage 0 -> every beat has rom_addr 0 and tw_real=0x7FFF, tw_imag=0x0000; stage 5, j=8 -> addr 8 and tw_real=0x5A82, tw_imag=0xA57E.
REQ-033 Scenario: stage 4 -> address sequence 0,2,4,...,30 repeating twice; stage 1 -> 0,16 alternating.
REQ-034 Scenario: tw_ready randomly toggled at 50% -> exactly 192 beats, in order, with no duplicates, and outputs stable while stalled.
REQ-035 Scenario: rst at beat 100 -> tw_valid low the next cycle, no done pulse; a subsequent start restarts from s=0, j=0.
REQ-036 Scenario: start pulsed during busy, and in the done cycle -> ignored, and the beat count stays 192.
